vdp_super_palette: RTL and testbench

- Palette stage directly downstream of the super-res pixel fetch: converts the 8-bit super_high_res_palette_addr stream into 24-bit RGB for the video output mux.
- Holds a 256x24 palette RAM written by the CPU through an index/data byte sequencer (R, G, B per entry).
- After reset, fills the RAM with a default GRB 3-3-2 palette.

---
 rtl/vdp_super_pkg.sv | 24 ++
 rtl/vdp_palette_ram.sv | 25 ++
 rtl/vdp_super_palette.sv | 119 +++++++++++
 tb/tb_vdp_super_palette.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/vdp_super_pkg.sv
// Shared types and helpers for the super-res palette stage.
package vdp_super_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    typedef enum logic [1:0] {PH_R, PH_G, PH_B} pal_phase_t;
    typedef enum logic {PAL_INIT, PAL_RUN} pal_state_t;

    localparam int PALETTE_READ_LATENCY = 2;

    // GRB 3-3-2 default entry, each field widened by bit replication.
    function automatic rgb24_t default_332(input logic [7:0] i);
        rgb24_t c;
        c.r = {i[4:2], i[4:2], i[4:3]};
        c.g = {i[7:5], i[7:5], i[7:6]};
        c.b = {i[1:0], i[1:0], i[1:0], i[1:0]};
        return c;
    endfunction

endpackage

// File: rtl/vdp_palette_ram.sv
// 256x24 simple dual-port palette RAM; registered read returns old data on collision.
module vdp_palette_ram (
    input  logic        clk,
    input  logic        i_we,
    input  logic [7:0]  i_waddr,
    input  logic [23:0] i_wdata,
    input  logic [7:0]  i_raddr,
    output logic [23:0] o_rdata
);

    logic [23:0] r_mem [256];
    logic [23:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vdp_super_palette.sv
// Palette stage: CPU byte sequencer plus default-fill FSM feeding a 2-cycle RAM lookup.
module vdp_super_palette
    import vdp_super_pkg::*;
#(
    parameter bit INIT_DEFAULT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  super_high_res_palette_addr,
    input  logic        pixel_valid,
    input  logic        pal_index_wr,
    input  logic        pal_data_wr,
    input  logic [7:0]  pal_wdata,
    output logic        pal_busy,
    output logic [23:0] rgb_out,
    output logic        rgb_valid
);

    pal_state_t r_state, w_state_nxt;
    logic [7:0] r_fill_idx;
    logic       w_fill_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= INIT_DEFAULT ? PAL_INIT : PAL_RUN;
            r_fill_idx <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_fill_idx <= (r_state == PAL_INIT) ? r_fill_idx + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fill_we   = 1'b0;
        case (r_state)
            PAL_INIT: begin
                w_fill_we = 1'b1;
                if (r_fill_idx == 8'hFF)
                    w_state_nxt = PAL_RUN;
            end
            default: w_state_nxt = PAL_RUN;
        endcase
    end

    logic       w_run;
    logic       w_commit;
    logic [7:0] r_wr_idx;
    logic [7:0] r_red, r_green;
    pal_phase_t r_phase;

    assign w_run    = (r_state == PAL_RUN);
    assign pal_busy = (r_state == PAL_INIT);
    // An index write in the same cycle swallows the data byte.
    assign w_commit = w_run && pal_data_wr && !pal_index_wr && (r_phase == PH_B);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_idx <= 8'd0;
            r_phase  <= PH_R;
            r_red    <= 8'd0;
            r_green  <= 8'd0;
        end else if (pal_index_wr) begin
            r_wr_idx <= pal_wdata;
            r_phase  <= PH_R;
        end else if (w_run && pal_data_wr) begin
            case (r_phase)
                PH_R: begin
                    r_red   <= pal_wdata;
                    r_phase <= PH_G;
                end
                PH_G: begin
                    r_green <= pal_wdata;
                    r_phase <= PH_B;
                end
                default: begin
                    r_wr_idx <= r_wr_idx + 8'd1;
                    r_phase  <= PH_R;
                end
            endcase
        end
    end

    logic        w_we;
    logic [7:0]  w_waddr;
    rgb24_t      w_wdata;
    logic [23:0] w_rd_data;

    assign w_we    = !reset && (w_fill_we || w_commit);
    assign w_waddr = w_fill_we ? r_fill_idx : r_wr_idx;
    assign w_wdata = w_fill_we ? default_332(r_fill_idx) : rgb24_t'({r_red, r_green, pal_wdata});

    vdp_palette_ram u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (super_high_res_palette_addr),
        .o_rdata (w_rd_data)
    );

    logic [PALETTE_READ_LATENCY:1] r_vld_pipe;
    logic [23:0]                   r_rgb;

    // Output gating uses the live state, so nothing reaches rgb_out while the fill runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_pipe <= '0;
            r_rgb      <= 24'd0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[PALETTE_READ_LATENCY-1:1], pixel_valid};
            r_rgb      <= (r_vld_pipe[1] && w_run) ? w_rd_data : 24'd0;
        end
    end

    assign rgb_out   = r_rgb;
    assign rgb_valid = r_vld_pipe[PALETTE_READ_LATENCY];

endmodule

// File: tb/tb_vdp_super_palette.sv
// Directed self-checking bench for vdp_super_palette.
module tb_vdp_super_palette;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  addr;
    logic        pix_vld;
    logic        idx_wr;
    logic        dat_wr;
    logic [7:0]  wdata;
    logic        busy;
    logic [23:0] rgb;
    logic        rgb_vld;

    int checks   = 0;
    int failures = 0;

    vdp_super_palette #(.INIT_DEFAULT(1'b1)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .super_high_res_palette_addr (addr),
        .pixel_valid                 (pix_vld),
        .pal_index_wr                (idx_wr),
        .pal_data_wr                 (dat_wr),
        .pal_wdata                   (wdata),
        .pal_busy                    (busy),
        .rgb_out                     (rgb),
        .rgb_valid                   (rgb_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_index(input logic [7:0] v);
        idx_wr = 1'b1; wdata = v;
        tick();
        idx_wr = 1'b0;
    endtask

    task automatic cpu_data(input logic [7:0] v);
        dat_wr = 1'b1; wdata = v;
        tick();
        dat_wr = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [23:0] exp);
        addr = a; pix_vld = 1'b1;
        tick();
        tick();
        chk(tag, rgb, exp);
        chk({tag, "_vld"}, rgb_vld, 1'b1);
        pix_vld = 1'b0;
        tick();
        tick();
        chk({tag, "_vld_off"}, rgb_vld, 1'b0);
        chk({tag, "_zero"}, rgb, 24'h0);
    endtask

    int busy_cnt;
    int rgb_nz;

    initial begin
        reset = 1'b1; addr = 8'h00; pix_vld = 1'b0;
        idx_wr = 1'b0; dat_wr = 1'b0; wdata = 8'h00;
        tick();
        tick();
        chk("rst_busy", busy, 1'b1);
        chk("rst_rgb", rgb, 24'h0);
        chk("rst_vld", rgb_vld, 1'b0);
        reset = 1'b0;

        busy_cnt = 0;
        for (int i = 0; i < 257; i++) begin
            if (busy) busy_cnt++;
            tick();
        end
        chk("fill_len", busy_cnt, 256);
        chk("run_busy", busy, 1'b0);

        rd("def_ff", 8'hFF, 24'hFFFFFF);
        rd("def_1c", 8'h1C, 24'hFF0000);
        rd("def_03", 8'h03, 24'h0000FF);

        cpu_index(8'h10);
        cpu_data(8'h12); cpu_data(8'h34); cpu_data(8'h56);
        cpu_data(8'hAA); cpu_data(8'hBB); cpu_data(8'hCC);
        rd("wr_10", 8'h10, 24'h123456);
        rd("wr_11", 8'h11, 24'hAABBCC);

        cpu_index(8'hFF);
        cpu_data(8'h01); cpu_data(8'h02); cpu_data(8'h03);
        cpu_data(8'h04); cpu_data(8'h05); cpu_data(8'h06);
        rd("wrap_ff", 8'hFF, 24'h010203);
        rd("wrap_00", 8'h00, 24'h040506);

        // Commit and read of 0x20 in the same cycle.
        cpu_index(8'h20);
        cpu_data(8'hDE); cpu_data(8'hAD);
        dat_wr = 1'b1; wdata = 8'hBE; addr = 8'h20; pix_vld = 1'b1;
        tick();
        dat_wr = 1'b0;
        tick();
        chk("coll_old", rgb, 24'h002400);
        tick();
        chk("coll_new", rgb, 24'hDEADBE);
        pix_vld = 1'b0;
        tick();
        tick();

        cpu_index(8'h05);
        cpu_data(8'h11); cpu_data(8'h22);
        cpu_index(8'h06);
        cpu_data(8'h01); cpu_data(8'h02); cpu_data(8'h03);
        rd("intr_05", 8'h05, 24'h240055);
        rd("intr_06", 8'h06, 24'h010203);

        // Simultaneous index+data: data byte dropped.
        idx_wr = 1'b1; dat_wr = 1'b1; wdata = 8'h30;
        tick();
        idx_wr = 1'b0; dat_wr = 1'b0;
        cpu_data(8'h07); cpu_data(8'h08); cpu_data(8'h09);
        rd("both_30", 8'h30, 24'h070809);

        // Reset, run the fill to entry 100, then reset again mid-fill.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        addr = 8'hFF; pix_vld = 1'b1;
        rgb_nz = 0;
        for (int i = 0; i < 100; i++) begin
            if (rgb != 24'h0) rgb_nz++;
            tick();
        end
        chk("mid_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 257; i++) begin
            idx_wr = (i == 10);
            dat_wr = (i >= 20 && i < 23);
            wdata  = (i == 10) ? 8'h40 : 8'h99;
            if (busy) busy_cnt++;
            if (busy && rgb != 24'h0) rgb_nz++;
            tick();
        end
        idx_wr = 1'b0; dat_wr = 1'b0;
        chk("refill_len", busy_cnt, 256);
        chk("fill_rgb_zero", rgb_nz, 0);
        chk("fill_vld", rgb_vld, 1'b1);
        pix_vld = 1'b0;
        tick();
        tick();

        cpu_data(8'hA1); cpu_data(8'hA2); cpu_data(8'hA3);
        rd("init_idx_40", 8'h40, 24'hA1A2A3);
        rd("refill_41", 8'h41, 24'h004955);
        rd("refill_10", 8'h10, 24'h920000);
        rd("refill_ff", 8'hFF, 24'hFFFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
